axi4lite_timer_slave: RTL and testbench

AXI4-Lite slave peripheral holding a 32-bit programmable down-counter timer with four memory-mapped registers and an interrupt output. It sits directly downstream of the pin-driven AXI4-Lite master and takes the place of the plain register-file slave on the same AW/W/B/AR/R channel set. It consumes the master's write and read transactions and returns timer state as read data.

---
 rtl/axi4lite_timer_slave.sv | 166 ++++++++++++++++
 tb/tb_axi4lite_timer_slave.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_timer_slave.sv
// AXI4-Lite slave wrapping a 32-bit programmable down-counter timer.
// Registers: CTRL (en/reload/ie), LOAD, COUNT, STATUS (W1C expired); level irq.
module axi4lite_timer_slave #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  irq
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic                  en_q, en_d;
    logic                  reload_q, reload_d;
    logic                  ie_q, ie_d;
    logic [DATA_WIDTH-1:0] load_q, load_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  expired_q, expired_d;
    logic                  bvalid_q, bvalid_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  expire;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [1:0]            wr_sel;
    logic [1:0]            rd_sel;
    logic                  unused_addr_bits;

    assign wr_sel = s_axi_awaddr[3:2];
    assign rd_sel = s_axi_araddr[3:2];

    // Byte-offset bits carry no meaning for word registers.
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    // Both write channels must be valid together; reset blocks every accept.
    assign wr_acc = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~rst;
    assign rd_acc = s_axi_arvalid & ~rvalid_q & ~rst;

    assign s_axi_awready = wr_acc;
    assign s_axi_wready  = wr_acc;
    assign s_axi_arready = rd_acc;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;
    assign irq           = expired_q & ie_q & ~rst;

    // Read mux over the pre-edge register state.
    always_comb begin
        rd_mux = '0;
        unique case (rd_sel)
            REG_CTRL:   rd_mux = {{(DATA_WIDTH-3){1'b0}}, ie_q, reload_q, en_q};
            REG_LOAD:   rd_mux = load_q;
            REG_COUNT:  rd_mux = count_q;
            REG_STATUS: rd_mux = {{(DATA_WIDTH-1){1'b0}}, expired_q};
        endcase
    end

    // Timer step first, then software writes override, then expiry wins over W1C.
    always_comb begin
        en_d      = en_q;
        reload_d  = reload_q;
        ie_d      = ie_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;
        expire    = 1'b0;
        if (en_q) begin
            if (count_q != '0) begin
                count_d = count_q - DATA_WIDTH'(1);
            end else begin
                expire = 1'b1;
                if (reload_q) begin
                    count_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end
        if (wr_acc) begin
            unique case (wr_sel)
                REG_CTRL: begin
                    en_d     = s_axi_wdata[0];
                    reload_d = s_axi_wdata[1];
                    ie_d     = s_axi_wdata[2];
                end
                REG_LOAD:  load_d = s_axi_wdata;
                REG_COUNT: count_d = s_axi_wdata;
                REG_STATUS: begin
                    if (s_axi_wdata[0]) begin
                        expired_d = 1'b0;
                    end
                end
            endcase
        end
        if (expire) begin
            expired_d = 1'b1;
        end
    end

    // Response channels: set on accept, held until the master takes them.
    always_comb begin
        bvalid_d = bvalid_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (wr_acc) begin
            bvalid_d = 1'b1;
        end else if (s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (rd_acc) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            reload_q  <= 1'b0;
            ie_q      <= 1'b0;
            load_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            en_q      <= en_d;
            reload_q  <= reload_d;
            ie_q      <= ie_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi4lite_timer_slave.sv
// Directed bench for axi4lite_timer_slave: vector table plus
// hand-timed sequences for counter, W1C race, backpressure and reset.
module tb_axi4lite_timer_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        irq;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    axi4lite_timer_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d,
                            output bit ok);
        int n;
        @(negedge clk);
        s_axi_awaddr  = a;
        s_axi_wdata   = d;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        #1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            total_cnt++;
            $display("FAIL wr_timeout: got no awready required accept");
        end
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        ok = (s_axi_bvalid === 1'b1) && (s_axi_bresp === 2'b00);
        @(posedge clk);
        #1;
        ok = ok && (s_axi_bvalid === 1'b0);
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d,
                           output bit ok);
        int n;
        @(negedge clk);
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b1;
        #1;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            total_cnt++;
            $display("FAIL rd_timeout: got no arready required accept");
        end
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
        d  = s_axi_rdata;
        ok = (s_axi_rvalid === 1'b1) && (s_axi_rresp === 2'b00);
        @(posedge clk);
        #1;
        ok = ok && (s_axi_rvalid === 1'b0);
    endtask

    initial begin
        bit          ok;
        logic [31:0] rd;
        int          bad;

        rst           = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_wdata   = '0;
        s_axi_araddr  = '0;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        s_axi_bready  = 1'b0;
        s_axi_rready  = 1'b0;

        vecs.push_back('{1'b0, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 4'h4, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 4'h8, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 4'hC, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 4'h4, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 4'h4, 32'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 4'h5, 32'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 4'h0, 32'hFFFFFFF6, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h0, 32'h6});
        vecs.push_back('{1'b1, 4'h8, 32'h12, 32'h0});
        vecs.push_back('{1'b0, 4'h8, 32'h0, 32'h12});
        vecs.push_back('{1'b1, 4'hC, 32'h1, 32'h0});
        vecs.push_back('{1'b0, 4'hC, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 4'h8, 32'h0, 32'h12});

        // Reset with requests asserted: every handshake output held low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs",
              {26'b0, s_axi_awready, s_axi_wready, s_axi_arready,
               s_axi_bvalid, s_axi_rvalid, irq}, 32'h0);
        check("rst_rdata", s_axi_rdata, 32'h0);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, ok);
                check($sformatf("vec%0d_bvalid", i), 32'(ok), 32'h1);
            end else begin
                do_read(vecs[i].addr, rd, ok);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
                check($sformatf("vec%0d_rvalid", i), 32'(ok), 32'h1);
            end
        end

        // One-shot: CTRL accept at E0, expiry visible after E6.
        do_write(4'h4, 32'd5, ok);
        do_write(4'h8, 32'd5, ok);
        do_write(4'h0, 32'h5, ok);
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) check("oneshot_irq_e5", 32'(irq), 32'h0);
            if (k == 6) check("oneshot_irq_e6", 32'(irq), 32'h1);
        end
        do_read(4'h0, rd, ok);
        check("oneshot_ctrl", rd, 32'h4);
        do_read(4'h8, rd, ok);
        check("oneshot_count", rd, 32'h0);
        do_read(4'hC, rd, ok);
        check("oneshot_status", rd, 32'h1);

        // Auto-reload, period 4: CTRL accept at A, expiries at A+1, A+5, A+9.
        do_write(4'hC, 32'h1, ok);
        do_write(4'h8, 32'h0, ok);
        do_write(4'h4, 32'd3, ok);
        do_write(4'h0, 32'h7, ok);
        check("ar_first", 32'(irq), 32'h1);
        do_write(4'hC, 32'h1, ok);
        check("ar_w1c", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        check("ar_a4", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        check("ar_period", 32'(irq), 32'h1);
        do_write(4'hC, 32'h1, ok);
        check("ar_w1c2", 32'(irq), 32'h0);
        @(posedge clk);
        do_write(4'hC, 32'h1, ok);
        check("w1c_vs_expiry", 32'(irq), 32'h1);
        do_write(4'h0, 32'h0, ok);

        // Backpressure on both response channels.
        do_write(4'h8, 32'h77, ok);
        @(negedge clk);
        s_axi_awaddr  = 4'h4;
        s_axi_wdata   = 32'h12345678;
        s_axi_araddr  = 4'h4;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        s_axi_bready  = 1'b0;
        s_axi_rready  = 1'b0;
        #1;
        check("bp_accept",
              {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
        @(posedge clk);
        #1;
        s_axi_awaddr = 4'h8;
        s_axi_wdata  = 32'h55;
        s_axi_araddr = 4'h8;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1 ||
                s_axi_rdata !== 32'd3 || s_axi_awready !== 1'b0 ||
                s_axi_wready !== 1'b0 || s_axi_arready !== 1'b0)
                bad++;
            @(posedge clk);
            #1;
        end
        check("bp_stable", 32'(bad), 32'h0);
        check("bp_rdata_old_load", s_axi_rdata, 32'd3);
        @(negedge clk);
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release",
              {28'b0, s_axi_bvalid, s_axi_rvalid, s_axi_awready,
               s_axi_arready}, 32'h3);
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        check("bp_next_valid", {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'h3);
        check("bp_next_rdata", s_axi_rdata, 32'h77);
        @(posedge clk);
        #1;
        do_read(4'h4, rd, ok);
        check("bp_load", rd, 32'h12345678);
        do_read(4'h8, rd, ok);
        check("bp_count", rd, 32'h55);

        // AW without W stalls; raising W accepts in that cycle.
        @(negedge clk);
        s_axi_awaddr  = 4'h4;
        s_axi_wdata   = 32'hA5A5A5A5;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        #1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        check("aw_only_stall", 32'(bad), 32'h0);
        s_axi_awvalid = 1'b0;
        do_read(4'h4, rd, ok);
        check("aw_only_nochange", rd, 32'h12345678);
        @(negedge clk);
        s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b1;
        #1;
        check("aw_then_w", {30'b0, s_axi_awready, s_axi_wready}, 32'h3);
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("aw_then_w_bvalid", 32'(s_axi_bvalid), 32'h1);
        @(posedge clk);
        #1;
        do_read(4'h4, rd, ok);
        check("aw_then_w_load", rd, 32'hA5A5A5A5);

        // Reset mid-count with both responses pending.
        do_write(4'h8, 32'd100, ok);
        do_write(4'h0, 32'h5, ok);
        check("pre_rst_irq", 32'(irq), 32'h1);
        @(negedge clk);
        s_axi_awaddr  = 4'h4;
        s_axi_wdata   = 32'hCAFE;
        s_axi_araddr  = 4'h4;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        s_axi_bready  = 1'b0;
        s_axi_rready  = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_pending", {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'h3);
        check("pre_rst_rdata", s_axi_rdata, 32'hA5A5A5A5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_outputs",
              {26'b0, s_axi_awready, s_axi_wready, s_axi_arready,
               s_axi_bvalid, s_axi_rvalid, irq}, 32'h0);
        check("midrst_rdata", s_axi_rdata, 32'h0);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            logic [3:0] ra;
            ra = 4'(r * 4);
            do_read(ra, rd, ok);
            check($sformatf("post_rst_reg%0d", r), rd, 32'h0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
